// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM encoding, default bit
// timing and data width.
package uart_pkg;

   localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
   localparam int unsigned DATA_W               = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The pointers carry an extra MSB
// so that full and empty can be told apart.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_Clock,
   input  logic                     i_Reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot the push is about to fill.
   assign do_push = push && (!full || do_pop);
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with input synchronizer, feeding a small receive FIFO.
// Frame errors and FIFO overruns are reported as single-cycle pulses.
module uart_rx_buffered
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          i_Clock,
   input  logic                          i_Reset,
   input  logic                          i_enable,
   input  logic                          i_RX,
   input  logic                          i_rd_en,
   output logic [DATA_W-1:0]             o_rd_data,
   output logic                          o_rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic                          o_RX_Active,
   output logic                          o_frame_err,
   output logic                          o_overrun
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   logic              rx_meta, rx_s;
   uart_state_t       state, state_nx;
   logic [CNT_W-1:0]  clk_cnt, cnt_nx;
   logic [2:0]        bit_idx, idx_nx;
   logic [DATA_W-1:0] shift, shift_nx;
   logic              push, ferr_nx, pop;
   logic              fifo_full, fifo_empty;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         rx_meta     <= 1'b1;
         rx_s        <= 1'b1;
         state       <= IDLE;
         clk_cnt     <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         rx_meta     <= i_RX;
         rx_s        <= rx_meta;
         state       <= state_nx;
         clk_cnt     <= cnt_nx;
         bit_idx     <= idx_nx;
         shift       <= shift_nx;
         o_frame_err <= ferr_nx;
         o_overrun   <= push && fifo_full && !pop;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = clk_cnt;
      idx_nx   = bit_idx;
      shift_nx = shift;
      push     = 1'b0;
      ferr_nx  = 1'b0;
      if (!i_enable) begin
         state_nx = IDLE;
         cnt_nx   = '0;
         idx_nx   = '0;
      end else begin
         case (state)
            IDLE: begin
               cnt_nx = '0;
               idx_nx = '0;
               if (!rx_s) state_nx = START;
            end
            START: begin
               if (clk_cnt == HALF_M1) begin
                  cnt_nx   = '0;
                  state_nx = rx_s ? IDLE : DATA;
               end else begin
                  cnt_nx = clk_cnt + 1'b1;
               end
            end
            DATA: begin
               if (clk_cnt == FULL_M1) begin
                  cnt_nx            = '0;
                  shift_nx[bit_idx] = rx_s;
                  if (bit_idx == 3'd7) begin
                     idx_nx   = '0;
                     state_nx = STOP;
                  end else begin
                     idx_nx = bit_idx + 3'd1;
                  end
               end else begin
                  cnt_nx = clk_cnt + 1'b1;
               end
            end
            STOP: begin
               if (clk_cnt == FULL_M1) begin
                  cnt_nx   = '0;
                  state_nx = IDLE;
                  push     = rx_s;
                  ferr_nx  = !rx_s;
               end else begin
                  cnt_nx = clk_cnt + 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   assign o_RX_Active = (state != IDLE);
   assign o_rd_valid  = !fifo_empty;
   assign pop         = i_rd_en && !fifo_empty;

   uart_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .push    (push),
      .pop     (pop),
      .wr_data (shift),
      .rd_data (o_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (o_count)
   );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Randomized bench for uart_rx_buffered: serial frames are driven bit by bit
// and the FIFO outputs are checked every cycle against a queue model.
module tb_uart_rx_buffered;

   localparam int CPB       = 16;
   localparam int DEPTH     = 4;
   localparam int FRAME     = 10 * CPB;
   localparam int STOP_BEG  = 9 * CPB;
   localparam int PUSH_EDGE = 2 + CPB / 2 + 9 * CPB;
   localparam int MID       = 5 * CPB;

   logic       i_Clock = 1'b0;
   logic       i_Reset, i_enable, i_RX, i_rd_en;
   logic [7:0] o_rd_data;
   logic       o_rd_valid, o_RX_Active, o_frame_err, o_overrun;
   logic [2:0] o_count;

   int         vectors = 0;
   int         miscompares = 0;
   bit         chk_en = 1'b0;
   logic [7:0] q[$];
   int         ferr_exp = 0, ovr_exp = 0;
   int         ferr_seen = 0, ovr_seen = 0;

   uart_rx_buffered #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .i_Clock     (i_Clock),
      .i_Reset     (i_Reset),
      .i_enable    (i_enable),
      .i_RX        (i_RX),
      .i_rd_en     (i_rd_en),
      .o_rd_data   (o_rd_data),
      .o_rd_valid  (o_rd_valid),
      .o_count     (o_count),
      .o_RX_Active (o_RX_Active),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun)
   );

   always #5 i_Clock = ~i_Clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_Clock);
      #1;
   endtask

   always @(negedge i_Clock) begin
      if (o_frame_err === 1'b1) ferr_seen++;
      if (o_overrun === 1'b1) ovr_seen++;
      if (chk_en) begin
         chk("count", o_count, q.size());
         chk("valid", o_rd_valid, q.size() != 0);
         if (q.size() != 0) chk("data", o_rd_data, q[0]);
      end
   end

   task automatic check_reset_outputs();
      chk("rst_valid", o_rd_valid, 0);
      chk("rst_count", o_count, 0);
      chk("rst_data", o_rd_data, 0);
      chk("rst_active", o_RX_Active, 0);
      chk("rst_ferr", o_frame_err, 0);
      chk("rst_ovr", o_overrun, 0);
   endtask

   task automatic pop_one();
      i_rd_en = 1'b1;
      tick();
      i_rd_en = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
   endtask

   // pop_edge/dis_at/rst_at: frame-relative cycle for a read, enable drop or reset; -1 = none
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input int pop_edge, input int dis_at, input int rst_at);
      logic [9:0] fr;
      bit aborted;
      fr = {stop_bit, b, 1'b0};
      aborted = 1'b0;
      for (int j = 0; j < FRAME; j++) begin
         if (j % CPB == 0) i_RX = fr[j / CPB];
         i_rd_en = (j == pop_edge);
         if (j == dis_at) i_enable = 1'b0;
         if (j == rst_at) begin
            chk_en  = 1'b0;
            i_RX    = 1'b1;
            i_Reset = 1'b1;
            q.delete();
            repeat (3) tick();
            check_reset_outputs();
            i_Reset = 1'b0;
            aborted = 1'b1;
            break;
         end
         if (j == STOP_BEG) chk_en = 1'b0;
         tick();
         if (j == MID && dis_at < 0) chk("active_mid", o_RX_Active, 1);
         if (j == dis_at) chk("active_disabled", o_RX_Active, 0);
      end
      i_RX    = 1'b1;
      i_rd_en = 1'b0;
      if (!aborted && dis_at < 0) begin
         if (pop_edge >= 0 && q.size() > 0) void'(q.pop_front());
         if (stop_bit) begin
            if (q.size() < DEPTH) q.push_back(b);
            else ovr_exp++;
         end else begin
            ferr_exp++;
         end
      end
      i_enable = 1'b1;
      tick();
      // A low stop bit looks like the next start bit; let it be rejected.
      if (!stop_bit || aborted) repeat (CPB) tick();
      chk_en = 1'b1;
      chk("ferr_pulses", ferr_seen, ferr_exp);
      chk("ovr_pulses", ovr_seen, ovr_exp);
      chk("active_idle", o_RX_Active, 0);
   endtask

   initial begin
      int n;
      i_Reset  = 1'b1;
      i_enable = 1'b1;
      i_RX     = 1'b1;
      i_rd_en  = 1'b0;
      repeat (3) tick();
      check_reset_outputs();
      i_Reset = 1'b0;
      repeat (4) tick();
      chk_en = 1'b1;

      pop_one();
      chk("empty_pop_count", o_count, 0);

      // single byte loopback
      send_frame(8'h3F, 1'b1, -1, -1, -1);
      chk("lb_valid", o_rd_valid, 1);
      chk("lb_data", o_rd_data, 8'h3F);
      chk("lb_count", o_count, 1);
      pop_one();
      chk("lb_count_after", o_count, 0);

      // frame error
      send_frame(8'hA5, 1'b0, -1, -1, -1);
      chk("ferr_valid", o_rd_valid, 0);
      chk("ferr_total", ferr_seen, 1);

      // start-bit glitch
      i_RX = 1'b0;
      repeat (4) tick();
      i_RX = 1'b1;
      repeat (2 * CPB) tick();
      chk("glitch_active", o_RX_Active, 0);
      chk("glitch_count", o_count, 0);
      chk("glitch_ferr", ferr_seen, 1);
      chk("glitch_ovr", ovr_seen, 0);

      // overrun on fifth byte
      for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, -1, -1, -1);
      chk("ovf_count", o_count, 4);
      chk("ovf_total", ovr_seen, 1);
      for (int k = 1; k <= 4; k++) begin
         chk("ovf_read", o_rd_data, k);
         pop_one();
      end
      chk("ovf_drained", o_rd_valid, 0);

      // simultaneous push and pop while full
      for (int k = 10; k <= 13; k++) send_frame(8'(k), 1'b1, -1, -1, -1);
      send_frame(8'h06, 1'b1, PUSH_EDGE, -1, -1);
      chk("pp_count", o_count, 4);
      chk("pp_ovr", ovr_seen, 1);
      repeat (3) pop_one();
      chk("pp_tail", o_rd_data, 8'h06);
      pop_one();

      // push and pop together while empty
      send_frame(8'h77, 1'b1, PUSH_EDGE, -1, -1);
      chk("pe_data", o_rd_data, 8'h77);

      // enable dropped mid-frame
      send_frame(8'h00, 1'b1, -1, 60, -1);
      chk("dis_count", o_count, 1);

      // reset during data bit 3, then a clean frame
      send_frame(8'h55, 1'b1, -1, -1, 4 * CPB + 6);
      send_frame(8'hC3, 1'b1, -1, -1, -1);
      chk("rst_rx_count", o_count, 1);
      chk("rst_rx_data", o_rd_data, 8'hC3);
      pop_one();

      // randomized traffic
      for (int r = 0; r < 20; r++) begin
         send_frame(8'($urandom), ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 3) == 0) ? PUSH_EDGE : -1, -1, -1);
         n = $urandom_range(0, 2);
         repeat (n) pop_one();
         n = $urandom_range(0, 5);
         repeat (n) tick();
      end
      while (q.size() > 0) pop_one();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx_buffered.md
UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, gives the clocks per serial bit (115200 baud at 50 MHz).
REQ-002 Parameter FIFO_DEPTH, default 4, gives the receive FIFO depth in bytes; the value SHALL be a power of two, 2 or greater.
REQ-003 i_Clock  input  1  single system clock; all logic SHALL be on the rising edge.
REQ-004 i_Reset  input  1  reset, synchronous and active-high.
REQ-005 i_enable  input  1  receiver enable; while low, the FSM SHALL be held in IDLE.
REQ-006 i_RX  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-007 i_rd_en  input  1  pop request for the FIFO head byte.
REQ-008 o_rd_data  output  8  FIFO head byte, valid while o_rd_valid is high.
REQ-009 o_rd_valid  output  1  FIFO not empty.
REQ-010 o_count  output  $clog2(FIFO_DEPTH)+1  number of bytes held in the FIFO.
REQ-011 o_RX_Active  output  1  high in every FSM state except IDLE.
REQ-012 o_frame_err  output  1  one-cycle pulse when a frame's stop bit is sampled low.
REQ-013 o_overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-014 i_RX SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value (rx_s).
REQ-015 FSM states SHALL be IDLE, START, DATA and STOP, with one clock counter (clk_cnt) and a 3-bit bit index.
REQ-016 IDLE: when rx_s is 0 and i_enable is 1, the FSM SHALL go to START with clk_cnt=0.
REQ-017 START: at clk_cnt = CLKS_PER_BIT/2-1, if rx_s=0 the FSM SHALL go to DATA with clk_cnt=0; otherwise it SHALL return to IDLE as a glitch, with no output.
REQ-018 DATA: at clk_cnt = CLKS_PER_BIT-1, rx_s SHALL be shifted into bit[index] LSB-first; after index 7 the FSM SHALL go to STOP.
REQ-019 STOP: at clk_cnt = CLKS_PER_BIT-1, if rx_s=1 the byte SHALL be pushed; if rx_s=0, o_frame_err SHALL pulse and the byte SHALL be discarded; in both cases the FSM SHALL go to IDLE.
REQ-020 o_rd_valid/o_rd_data SHALL reflect a pushed byte on the cycle after the stop-sample cycle (first-word fall-through).
REQ-021 A pop SHALL occur only when i_rd_en=1 and o_rd_valid=1; i_rd_en while empty SHALL be ignored.
REQ-022 Push while full without a simultaneous pop: the byte SHALL be dropped, o_overrun SHALL pulse, and FIFO contents SHALL be unchanged.
REQ-023 Simultaneous push and pop while full SHALL both succeed, o_count SHALL stay unchanged, and there SHALL be no overrun.
REQ-024 Simultaneous push and pop while empty: the push SHALL succeed and the pop SHALL be ignored.
REQ-025 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH, using an extra MSB for full/empty.
REQ-026 i_enable falling mid-frame SHALL abort the frame without a push or error pulse, and SHALL leave FIFO contents intact.

Reset
REQ-027 While i_Reset=1: FSM=IDLE, clk_cnt=0, index=0, shift register=0, synchronizer flops=1, FIFO pointers=0.
REQ-028 Output values during reset: o_rd_valid=0, o_count=0, o_rd_data=0, o_RX_Active=0, o_frame_err=0, o_overrun=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial byte; the next complete frame after release SHALL be received correctly.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state encoding, the default CLKS_PER_BIT, and the data width (8); it SHALL be shared with the transmitter.
REQ-031 The FIFO SHALL be a separate sub-module, uart_sync_fifo (parameters: width, depth; ports: push, pop, data, full, empty, count).

Verification
REQ-032 Loopback from the existing transmitter sending 0x3F at CLKS_PER_BIT=434 -> o_rd_valid rises, o_rd_data=0x3F, o_count=1; after one i_rd_en, o_count=0.
REQ-033 Frame 0xA5 driven with stop bit 0 -> one o_frame_err pulse; o_rd_valid stays 0.
REQ-034 i_RX low for 100 clocks, then high -> FSM returns to IDLE, no push, no pulses.
REQ-035 Bytes 0x01..0x05 back-to-back with no reads (FIFO_DEPTH=4) -> o_count=4, one o_overrun pulse at the fifth stop bit; reads return 0x01, 0x02, 0x03, 0x04.
REQ-036 With FIFO full, i_rd_en held in the cycle of a 0x06 push -> o_count stays 4, no overrun; the tail read returns 0x06.
REQ-037 i_Reset pulsed during DATA bit 3 of 0x55, then 0xC3 sent -> all outputs reset; the single byte received is 0xC3.
